riscv_mem_arbiter: RTL and testbench
====================================

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3, consecutive denied fetch cycles before fetch is promoted over data.
REQ-002 The block SHALL use one clock (clk); reset (x_reset) SHALL be synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 x_reset  input  1  synchronous active-high reset.
REQ-005 if_req  input  1  fetch request, held until granted.
REQ-006 if_addr  input  32  fetch word address, stable while if_req high.
REQ-007 if_gnt  output  1  fetch accepted this cycle.
REQ-008 if_rvalid  output  1  fetch data valid.
REQ-009 if_rdata  output  32  fetched instruction.
REQ-010 d_req  input  1  data request, held until granted.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  32  data address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_be  input  4  store byte enables.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  load data valid / store ack.
REQ-017 d_rdata  output  32  load data.
REQ-018 mem_en, mem_we  output  1 each  memory enable / write.
REQ-019 mem_addr, mem_wdata  output  32 each  memory address / write data.
REQ-020 mem_be  output  4  memory byte enables.
REQ-021 mem_rdata  input  32  memory read data, one cycle after mem_en.
REQ-022 stall  output  1  core must hold PC/pipeline this cycle.

Function
REQ-023 Grant SHALL be combinational: at most one of if_gnt/d_gnt high per cycle; the granted request drives mem_* in the same cycle with mem_en=1.
REQ-024 Default priority SHALL be data over fetch.
REQ-025 A starvation counter SHALL increment each cycle if_req=1 and if_gnt=0, saturate at STARVE_LIMIT, and clear on if_gnt or if_req=0.
REQ-026 When counter == STARVE_LIMIT and if_req=1, fetch SHALL win over a simultaneous d_req.
REQ-027 Owner register (OWN_NONE/OWN_IF/OWN_D) SHALL record the grant each cycle; next cycle the owner's rvalid SHALL pulse for exactly one cycle.
REQ-028 Back-to-back grants SHALL be allowed every cycle (throughput one access/cycle, latency 1).
REQ-029 if_rdata/d_rdata SHALL equal mem_rdata when the corresponding rvalid=1, else 0.
REQ-030 Store grants SHALL produce d_rvalid=1 next cycle with d_rdata=0.
REQ-031 When no grant, mem_en=0, mem_we=0, mem_addr/mem_wdata/mem_be SHALL be 0.
REQ-032 mem_we SHALL be 1 only for a data grant with d_we=1; fetch grants use mem_be=4'hF.
REQ-033 stall SHALL equal (if_req & ~if_gnt) | (d_req & ~d_gnt).
REQ-034 Counter width SHALL be $clog2(STARVE_LIMIT+1); STARVE_LIMIT=0 SHALL mean fetch always promoted when requesting.

Reset
REQ-035 While x_reset=1: if_gnt, d_gnt, mem_en, mem_we = 0; stall = 0.
REQ-036 After reset edge: owner=OWN_NONE, counter=0, if_rvalid=d_rvalid=0.
REQ-037 Reset asserted with a grant outstanding SHALL drop the response: no rvalid in the following cycle.

Structure
REQ-038 Enum MEM_OWNER {OWN_NONE, OWN_IF, OWN_D} SHALL live in the shared riscv_constants package.
REQ-039 One sub-module, riscv_starve_cnt (saturating counter, promote flag), is natural; the rest is flat.

Verification
REQ-040 if_req=1, addr 0x100, d_req=0 -> if_gnt same cycle, mem_addr=0x100, if_rvalid + mem_rdata next cycle.
REQ-041 if_req and d_req (load 0x2000) together -> d_gnt, if_gnt=0, stall=1; d_rvalid next cycle.
REQ-042 d_req held 5 cycles with if_req, STARVE_LIMIT=3 -> if_gnt on cycle 4, d_gnt resumes cycle 5.
REQ-043 Store d_we=1, be=4'b0011, data 0xDEADBEEF -> mem_we=1, mem_be=0011; d_rvalid next cycle, d_rdata=0.
REQ-044 Grant in cycle N, x_reset=1 in N+1 -> no rvalid, owner OWN_NONE, counter 0.
REQ-045 Alternating grants every cycle for 16 cycles -> each rvalid routed to correct owner, no gaps.

Source files
------------

// File: rtl/riscv_constants_pkg.sv
// rtl/riscv_constants_pkg.sv - shared constants for the riscv memory arbiter
package riscv_constants;

  // Which requester owns the memory response arriving next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } mem_owner_t;

  // Instruction fetches always read a full word
  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/riscv_starve_cnt.sv
// rtl/riscv_starve_cnt.sv - saturating fetch starvation counter with promote flag
module riscv_starve_cnt #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic x_reset,
  input  logic if_req,
  input  logic if_gnt,
  output logic promote
);

  // A limit of zero still needs a one-bit register; it simply never leaves 0
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;

  // Count denied fetch cycles, saturate at the limit, clear on grant or idle
  always_ff @(posedge clk) begin
    if (x_reset) begin
      cnt <= '0;
    end else if (!if_req || if_gnt) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fetch is promoted once it has waited the full limit
  always_comb begin
    promote = if_req && (cnt == LIMIT);
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - single-port memory arbiter between fetch and data
module riscv_mem_arbiter
  import riscv_constants::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        x_reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  mem_owner_t owner;
  mem_owner_t owner_next;
  logic       store_q;
  logic       promote;

  riscv_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .x_reset (x_reset),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .promote (promote)
  );

  // Record who was granted so the response next cycle is routed to them
  always_ff @(posedge clk) begin
    if (x_reset) begin
      owner   <= OWN_NONE;
      store_q <= 1'b0;
    end else begin
      owner   <= owner_next;
      store_q <= d_gnt && d_we;
    end
  end

  // Combinational grant, memory drive and response routing
  always_comb begin
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    owner_next = OWN_NONE;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    stall      = 1'b0;

    if (!x_reset) begin
      // Data wins by default; a starved fetch takes the port
      if_gnt = if_req && (!d_req || promote);
      d_gnt  = d_req && !if_gnt;
      stall  = (if_req && !if_gnt) || (d_req && !d_gnt);
    end

    if (if_gnt) begin
      owner_next = OWN_IF;
      mem_en     = 1'b1;
      mem_addr   = if_addr;
      mem_be     = FETCH_BE;
    end else if (d_gnt) begin
      owner_next = OWN_D;
      mem_en     = 1'b1;
      mem_we     = d_we;
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
      mem_be     = d_be;
    end

    // A reset arriving while a response is pending drops that response
    if_rvalid = !x_reset && (owner == OWN_IF);
    d_rvalid  = !x_reset && (owner == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !store_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - directed self-checking bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        x_reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        stall;

  logic        if_gnt0, if_rvalid0, d_gnt0, d_rvalid0, mem_en0, mem_we0, stall0;
  logic [31:0] if_rdata0, d_rdata0, mem_addr0, mem_wdata0;
  logic [3:0]  mem_be0;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .x_reset(x_reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  riscv_mem_arbiter #(.STARVE_LIMIT(0)) dut0 (
    .clk(clk), .x_reset(x_reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt0),
    .if_rvalid(if_rvalid0), .if_rdata(if_rdata0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_be(mem_be0), .mem_rdata(mem_rdata),
    .stall(stall0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge, then settle to the falling edge
  task automatic drive(input logic rst, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic we, input logic [31:0] da,
                       input logic [31:0] wd, input logic [3:0] be, input logic [31:0] rd);
    @(posedge clk);
    #1;
    x_reset = rst; if_req = ir; if_addr = ia;
    d_req = dr; d_we = we; d_addr = da; d_wdata = wd; d_be = be;
    mem_rdata = rd;
    @(negedge clk);
  endtask

  logic exp_if [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    x_reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;

    // Reset with both requesters active: nothing granted, no stall
    drive(1, 1, 32'h100, 1, 0, 32'h2000, 0, 0, 0);
    check("rst_if_gnt", {31'b0, if_gnt}, 0);
    check("rst_d_gnt", {31'b0, d_gnt}, 0);
    check("rst_mem_en", {31'b0, mem_en}, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_stall", {31'b0, stall}, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_if_rvalid", {31'b0, if_rvalid}, 0);
    check("post_rst_d_rvalid", {31'b0, d_rvalid}, 0);
    check("idle_mem_addr", mem_addr, 0);
    check("idle_mem_be", {28'b0, mem_be}, 0);

    // Lone fetch
    drive(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("f_if_gnt", {31'b0, if_gnt}, 1);
    check("f_mem_en", {31'b0, mem_en}, 1);
    check("f_mem_addr", mem_addr, 32'h100);
    check("f_mem_be", {28'b0, mem_be}, 32'hF);
    check("f_stall", {31'b0, stall}, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0013);
    check("f_if_rvalid", {31'b0, if_rvalid}, 1);
    check("f_if_rdata", if_rdata, 32'h13);
    check("f_d_rvalid", {31'b0, d_rvalid}, 0);
    check("f_d_rdata", d_rdata, 0);

    // Contention: data wins, fetch stalls; limit 0 instance promotes fetch
    drive(0, 1, 32'h104, 1, 0, 32'h2000, 0, 4'hF, 0);
    check("c_d_gnt", {31'b0, d_gnt}, 1);
    check("c_if_gnt", {31'b0, if_gnt}, 0);
    check("c_stall", {31'b0, stall}, 1);
    check("c_mem_addr", mem_addr, 32'h2000);
    check("c_lim0_if_gnt", {31'b0, if_gnt0}, 1);
    check("c_lim0_d_gnt", {31'b0, d_gnt0}, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D);
    check("c_d_rvalid", {31'b0, d_rvalid}, 1);
    check("c_d_rdata", d_rdata, 32'hCAFE_F00D);
    check("c_if_rvalid", {31'b0, if_rvalid}, 0);
    check("c_if_rdata", if_rdata, 0);

    // Starvation: fetch promoted on the 4th contested cycle
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h200, 1, 0, 32'h3000 + 32'(4 * i), 0, 4'hF, 32'h0);
      check($sformatf("s%0d_if_gnt", i), {31'b0, if_gnt}, {31'b0, exp_if[i]});
      check($sformatf("s%0d_d_gnt", i), {31'b0, d_gnt}, {31'b0, ~exp_if[i]});
      if (i > 0) begin
        check($sformatf("s%0d_if_rvalid", i), {31'b0, if_rvalid}, {31'b0, exp_if[i-1]});
        check($sformatf("s%0d_d_rvalid", i), {31'b0, d_rvalid}, {31'b0, ~exp_if[i-1]});
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s_tail_d_rvalid", {31'b0, d_rvalid}, 1);

    // Store
    drive(0, 0, 0, 1, 1, 32'h400, 32'hDEAD_BEEF, 4'b0011, 0);
    check("st_d_gnt", {31'b0, d_gnt}, 1);
    check("st_mem_we", {31'b0, mem_we}, 1);
    check("st_mem_be", {28'b0, mem_be}, 32'h3);
    check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("st_mem_addr", mem_addr, 32'h400);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
    check("st_d_rvalid", {31'b0, d_rvalid}, 1);
    check("st_d_rdata", d_rdata, 0);
    check("st_idle_mem_we", {31'b0, mem_we}, 0);

    // Grant outstanding then reset: response dropped, counter cleared
    drive(0, 1, 32'h500, 1, 0, 32'h6000, 0, 4'hF, 0);
    drive(0, 1, 32'h500, 1, 0, 32'h6004, 0, 4'hF, 0);
    check("r_pre_d_gnt", {31'b0, d_gnt}, 1);
    drive(1, 1, 32'h500, 1, 0, 32'h6008, 0, 4'hF, 32'h55);
    check("r_d_rvalid", {31'b0, d_rvalid}, 0);
    check("r_d_rdata", d_rdata, 0);
    check("r_d_gnt", {31'b0, d_gnt}, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h500, 1, 0, 32'h7000, 0, 4'hF, 0);
      if (i == 0) begin
        check("r_after_d_rvalid", {31'b0, d_rvalid}, 0);
        check("r_after_if_rvalid", {31'b0, if_rvalid}, 0);
      end
      check($sformatf("r%0d_if_gnt", i), {31'b0, if_gnt}, (i == 3) ? 32'd1 : 32'd0);
    end

    // Alternating fetch / load every cycle
    for (int i = 0; i <= 16; i++) begin
      if (i == 16)
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'hA000_0000 | 32'(i - 1));
      else if (i % 2 == 0)
        drive(0, 1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0, 0, 32'hA000_0000 | 32'(i - 1));
      else
        drive(0, 0, 0, 1, 0, 32'h5000 + 32'(4 * i), 0, 4'hF, 32'hA000_0000 | 32'(i - 1));
      if (i < 16) begin
        check($sformatf("a%0d_mem_addr", i), mem_addr,
              (i % 2 == 0) ? 32'h1000 + 32'(4 * i) : 32'h5000 + 32'(4 * i));
      end
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          check($sformatf("a%0d_if_rdata", i), if_rdata, 32'hA000_0000 | 32'(i - 1));
          check($sformatf("a%0d_d_rvalid", i), {31'b0, d_rvalid}, 0);
        end else begin
          check($sformatf("a%0d_d_rdata", i), d_rdata, 32'hA000_0000 | 32'(i - 1));
          check($sformatf("a%0d_if_rvalid", i), {31'b0, if_rvalid}, 0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
